// File: rtl/silife_gen_scheduler_if.sv
// Wishbone slave bus bundle for the generation scheduler.
// The signal names are the scheduler's own port names, so a reader can match them to the register map.
// The master modport drives the request. The slave modport drives the acknowledge and the read data.
interface silife_gen_scheduler_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/silife_gen_scheduler.sv
// Generation scheduler for the life matrix.
// Issues a one-cycle gen_step strobe in three cases: free-running at PERIOD+1 cycles per step,
// on single-step writes, and until an optional generation limit stops it.
// Optional macro SILIFE_GEN_IRQ_EN: it adds CTRL bit5 irq_en, and gen_irq = done && irq_en.
// When SILIFE_GEN_IRQ_EN is undefined, gen_irq stays 0 and CTRL bit5 always reads 0.
module silife_gen_scheduler #(
   parameter int unsigned            PERIOD_BITS  = 24,
   parameter int unsigned            COUNT_BITS   = 32,
   parameter logic [PERIOD_BITS-1:0] PERIOD_RESET = 24'd999_999
) (
   input  logic                  clk,
   input  logic                  reset,
   silife_gen_scheduler_if.slave bus,
   output logic                  gen_step,
   output logic                  running,
   output logic                  gen_irq
);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;
   typedef enum logic [1:0] {REG_CTRL, REG_PERIOD, REG_COUNT, REG_LIMIT} reg_e;

   state_e                 state;
   logic [PERIOD_BITS-1:0] period;
   logic [PERIOD_BITS-1:0] timer;
   logic [COUNT_BITS-1:0]  gen_count;
   logic [COUNT_BITS-1:0]  limit;
   logic                   limit_en;
   logic                   done;
   logic                   irq_en;
   logic                   ack_q;
   logic [31:0]            rdata_q;

   logic                   wb_xfer;
   logic                   wr;
   logic                   rd;
   reg_e                   sel;
   logic                   wr_ctrl;
   logic                   is_run;
   logic                   run_fire;
   logic                   single_fire;
   logic                   step_fire;
   logic [COUNT_BITS-1:0]  count_inc;
   logic                   limit_hit;
   logic [31:0]            ctrl_rd;
   logic [31:0]            rd_mux;

   // Only addr[3:2] selects a register; the remaining address bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_wb_addr[31:4], bus.i_wb_addr[1:0]};

   // Bus decode and step/limit decisions for the coming edge.
   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      wb_xfer     = bus.i_wb_cyc && bus.i_wb_stb && !ack_q;
      wr          = wb_xfer && bus.i_wb_we;
      rd          = wb_xfer && !bus.i_wb_we;
      sel         = reg_e'(bus.i_wb_addr[3:2]);
      wr_ctrl     = wr && (sel == REG_CTRL);
      is_run      = (state == ST_RUN);
      run_fire    = is_run && (timer == '0);
      single_fire = wr_ctrl && bus.i_wb_data[1] && !is_run;
      step_fire   = run_fire || single_fire;
      count_inc   = gen_count + COUNT_BITS'(1);
      limit_hit   = step_fire && limit_en && (count_inc == limit);
   end

   // Read-data multiplexer. The step bit and the clear bit are write-only strobes, so they read as 0.
   always_comb begin
      ctrl_rd    = '0;
      ctrl_rd[0] = is_run;
      ctrl_rd[2] = limit_en;
      ctrl_rd[4] = done;
`ifdef SILIFE_GEN_IRQ_EN
      ctrl_rd[5] = irq_en;
`endif
      rd_mux = '0;
      case (sel)
         REG_CTRL:   rd_mux = ctrl_rd;
         REG_PERIOD: rd_mux[PERIOD_BITS-1:0] = period;
         REG_COUNT:  rd_mux[COUNT_BITS-1:0]  = gen_count;
         REG_LIMIT:  rd_mux[COUNT_BITS-1:0]  = limit;
         default:    rd_mux = '0;
      endcase
   end

   // Run FSM, period timer, counter, limit logic and wishbone response, all on one edge.
   // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         period    <= PERIOD_RESET;
         timer     <= '0;
         gen_count <= '0;
         limit     <= '0;
         limit_en  <= 1'b0;
         done      <= 1'b0;
         irq_en    <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         gen_step  <= 1'b0;
      end else begin
         ack_q    <= wb_xfer;
         gen_step <= step_fire;
         if (rd) rdata_q <= rd_mux;

         // A CTRL write sets run directly. The write wins over an auto-stop in the same cycle.
         if (wr_ctrl) state <= bus.i_wb_data[0] ? ST_RUN : ST_IDLE;
         else if (limit_hit) state <= ST_IDLE;

         // The timer loads only on an idle-to-run write, so rewriting run=1 does not restart it.
         if (wr_ctrl && bus.i_wb_data[0] && !is_run) timer <= period;
         else if (run_fire) timer <= period;
         else if (is_run) timer <= timer - PERIOD_BITS'(1);

         if (wr_ctrl) limit_en <= bus.i_wb_data[2];
`ifdef SILIFE_GEN_IRQ_EN
         if (wr_ctrl) irq_en <= bus.i_wb_data[5];
`endif

         // A new limit event takes priority over a W1C of done in the same cycle.
         if (limit_hit) done <= 1'b1;
         else if (wr_ctrl && bus.i_wb_data[4]) done <= 1'b0;

         if (wr && sel == REG_PERIOD) period <= bus.i_wb_data[PERIOD_BITS-1:0];
         if (wr && sel == REG_LIMIT) limit <= bus.i_wb_data[COUNT_BITS-1:0];

         // Clearing the count takes priority over a step in the same cycle.
         if (wr_ctrl && bus.i_wb_data[3]) gen_count <= '0;
         else if (step_fire) gen_count <= count_inc;
      end
   end

   assign bus.o_wb_ack  = ack_q;
   assign bus.o_wb_data = rdata_q;
   assign running       = is_run;

`ifdef SILIFE_GEN_IRQ_EN
   assign gen_irq = done && irq_en;
`else
   assign gen_irq = 1'b0;
`endif

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// Directed testbench for silife_gen_scheduler.
// Each scenario is a task that drives the bus and compares the observed outputs with hand-computed values.
module tb_silife_gen_scheduler;
   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_PERIOD = 32'h4;
   localparam logic [31:0] A_COUNT  = 32'h8;
   localparam logic [31:0] A_LIMIT  = 32'hC;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic gen_step;
   logic running;
   logic gen_irq;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   silife_gen_scheduler_if bus();

   silife_gen_scheduler dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .gen_step (gen_step),
      .running  (running),
      .gen_irq  (gen_irq)
   );

   always #5 clk = ~clk;

   // Count every cycle in which gen_step is high, sampled away from the active edge.
   always @(negedge clk) if (gen_step === 1'b1) pulses <= pulses + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   // Single write. On return the bench is 1 ns after the acknowledging edge.
   task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, output logic step_at_ack);
      logic got;
      int   n;
      got = 1'b0;
      n   = 0;
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = 1'b1;
      bus.i_wb_addr = addr;
      bus.i_wb_data = data;
      while (!got && n < 4) begin
         @(posedge clk); #1;
         n++;
         if (bus.o_wb_ack === 1'b1) got = 1'b1;
      end
      step_at_ack  = gen_step;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      bus.i_wb_we  = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_write_ack addr=%h: ack=%b, required 1 within 4 cycles", addr, bus.o_wb_ack);
      end
   endtask

   task automatic wb_wr(input logic [31:0] addr, input logic [31:0] data);
      logic dummy;
      wb_write(addr, data, dummy);
   endtask

   task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int waited);
      logic got;
      got    = 1'b0;
      waited = 0;
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = addr;
      while (!got && waited < 4) begin
         @(posedge clk); #1;
         waited++;
         if (bus.o_wb_ack === 1'b1) got = 1'b1;
      end
      data         = bus.o_wb_data;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_read_ack addr=%h: ack=%b, required 1 within 4 cycles", addr, bus.o_wb_ack);
      end
   endtask

   // Record gen_step after each of the next n edges. Bit k-1 holds the value after edge k.
   task automatic sample_steps(input int n, output logic [63:0] mask);
      mask = '0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         mask[k] = gen_step;
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      int          w;
      int          acks;
      wait_cycles(3);
      checks++;
      if ({gen_step, running, gen_irq, bus.o_wb_ack} !== 4'b0000 || bus.o_wb_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: step/run/irq/ack=%b data=%h, required 0000 and 0",
                  {gen_step, running, gen_irq, bus.o_wb_ack}, bus.o_wb_data);
      end
      reset = 1'b0;
      wb_read(A_CTRL, d, w);
      checks++;
      if (d !== 32'h0 || w != 1) begin
         errors++; $display("FAIL reset_ctrl: got %h after %0d cycles, required 0 after 1", d, w);
      end
      wb_read(A_PERIOD, d, w);
      checks++;
      if (d !== 32'd999_999 || w != 2) begin
         errors++; $display("FAIL reset_period: got %0d after %0d cycles, required 999999 after 2", d, w);
      end
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'h0 || w != 2) begin
         errors++; $display("FAIL reset_count: got %h after %0d cycles, required 0 after 2", d, w);
      end
      wb_read(A_LIMIT, d, w);
      checks++;
      if (d !== 32'h0 || w != 2) begin
         errors++; $display("FAIL reset_limit: got %h after %0d cycles, required 0 after 2", d, w);
      end
      // Read data holds across the following write.
      wb_read(A_PERIOD, d, w);
      wb_wr(A_LIMIT, 32'd7);
      checks++;
      if (bus.o_wb_data !== 32'd999_999) begin
         errors++; $display("FAIL rdata_hold: got %0d, required 999999", bus.o_wb_data);
      end
      // GEN_COUNT ignores writes.
      wb_wr(A_COUNT, 32'h1234);
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL count_readonly: got %h, required 0", d);
      end
      // A strobe held for two edges is acked only once.
      wait_cycles(1);
      acks = 0;
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = A_LIMIT;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         if (bus.o_wb_ack === 1'b1) acks++;
      end
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      checks++;
      if (acks != 1 || bus.o_wb_data !== 32'd7) begin
         errors++; $display("FAIL held_strobe: acks=%0d data=%0d, required 1 ack and 7", acks, bus.o_wb_data);
      end
   endtask

   task automatic test_free_run;
      logic [63:0] m;
      logic [31:0] d;
      int          w;
      wb_wr(A_PERIOD, 32'd3);
      wb_wr(A_CTRL, 32'h1);
      sample_steps(12, m);
      checks++;
      if (m[11:0] !== 12'h888) begin
         errors++; $display("FAIL free_run_steps: mask=%h, required 888", m[11:0]);
      end
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'd3 || running !== 1'b1) begin
         errors++; $display("FAIL free_run_count: count=%0d running=%b, required 3 and 1", d, running);
      end
      wb_wr(A_CTRL, 32'h8);
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'd0 || running !== 1'b0) begin
         errors++; $display("FAIL stop_clear: count=%0d running=%b, required 0 and 0", d, running);
      end
   endtask

   task automatic test_single_step;
      logic        s;
      logic [31:0] d;
      int          w;
      int          p0;
      p0 = pulses;
      for (int k = 0; k < 3; k++) begin
         wb_write(A_CTRL, 32'h2, s);
         checks++;
         if (s !== 1'b1) begin
            errors++; $display("FAIL single_step_%0d: step at ack=%b, required 1", k, s);
         end
      end
      wait_cycles(2);
      checks++;
      if (pulses - p0 != 3) begin
         errors++; $display("FAIL single_step_pulses: got %0d, required 3", pulses - p0);
      end
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'd3) begin
         errors++; $display("FAIL single_step_count: got %0d, required 3", d);
      end
      wb_wr(A_PERIOD, 32'd1000);
      wb_wr(A_CTRL, 32'h1);
      p0 = pulses;
      for (int k = 0; k < 3; k++) wb_wr(A_CTRL, 32'h3);
      wait_cycles(2);
      wb_read(A_COUNT, d, w);
      checks++;
      if (pulses - p0 != 0 || d !== 32'd3) begin
         errors++; $display("FAIL step_while_running: pulses=%0d count=%0d, required 0 and 3", pulses - p0, d);
      end
      wb_wr(A_CTRL, 32'h8);
   endtask

   task automatic test_limit;
      logic [31:0] d;
      int          w;
      int          p0;
      wb_wr(A_PERIOD, 32'd1);
      wb_wr(A_LIMIT, 32'd5);
      p0 = pulses;
      wb_wr(A_CTRL, 32'h5);
      wait_cycles(16);
      checks++;
      if (pulses - p0 != 5 || running !== 1'b0) begin
         errors++; $display("FAIL limit_steps: pulses=%0d running=%b, required 5 and 0", pulses - p0, running);
      end
      wb_read(A_CTRL, d, w);
      checks++;
      if (d !== 32'h14) begin
         errors++; $display("FAIL limit_ctrl: got %h, required 14", d);
      end
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'd5) begin
         errors++; $display("FAIL limit_count: got %0d, required 5", d);
      end
      wb_wr(A_CTRL, 32'h14);
      wb_read(A_CTRL, d, w);
      checks++;
      if (d !== 32'h4) begin
         errors++; $display("FAIL done_w1c: got %h, required 4", d);
      end
      wb_wr(A_CTRL, 32'h8);
   endtask

   task automatic test_period_change_and_reset;
      logic [63:0] m;
      logic [31:0] d;
      int          w;
      wb_wr(A_PERIOD, 32'd2);
      wb_wr(A_CTRL, 32'h1);
      wb_wr(A_PERIOD, 32'd9);
      sample_steps(30, m);
      checks++;
      if (m[29:0] !== 30'h0010_0401) begin
         errors++; $display("FAIL period_change: mask=%h, required 00100401", m[29:0]);
      end
      // Reset lands on the edge where the next step would otherwise fire.
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (gen_step !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL reset_mid_run: step=%b running=%b, required 0 and 0", gen_step, running);
      end
      reset = 1'b0;
      wb_read(A_COUNT, d, w);
      checks++;
      if (d !== 32'd0) begin
         errors++; $display("FAIL reset_count_clear: got %0d, required 0", d);
      end
      wb_read(A_PERIOD, d, w);
      checks++;
      if (d !== 32'd999_999) begin
         errors++; $display("FAIL reset_period_restore: got %0d, required 999999", d);
      end
   endtask

   task automatic test_irq;
      logic [31:0] d;
      int          w;
      wb_wr(A_PERIOD, 32'd1);
      wb_wr(A_LIMIT, 32'd2);
      wb_wr(A_CTRL, 32'h25);
      wait_cycles(10);
`ifdef SILIFE_GEN_IRQ_EN
      checks++;
      if (gen_irq !== 1'b1) begin
         errors++; $display("FAIL irq_rise: gen_irq=%b, required 1", gen_irq);
      end
      wb_read(A_CTRL, d, w);
      checks++;
      if (d !== 32'h34) begin
         errors++; $display("FAIL irq_ctrl: got %h, required 34", d);
      end
      wb_wr(A_CTRL, 32'h30);
      checks++;
      if (gen_irq !== 1'b0) begin
         errors++; $display("FAIL irq_fall: gen_irq=%b, required 0", gen_irq);
      end
`else
      checks++;
      if (gen_irq !== 1'b0) begin
         errors++; $display("FAIL irq_tied: gen_irq=%b, required 0", gen_irq);
      end
      wb_read(A_CTRL, d, w);
      checks++;
      if (d !== 32'h14) begin
         errors++; $display("FAIL irq_bit_absent: got %h, required 14", d);
      end
`endif
   endtask

   initial begin
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = '0;
      bus.i_wb_data = '0;
      reset         = 1'b1;
      test_reset();
      test_free_run();
      test_single_step();
      test_limit();
      test_period_change_and_reset();
      test_irq();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
